sram_burst_reader: RTL and testbench

- Synchronous read controller for one sram128x8$ macro. It is the read-side counterpart of the existing write sequencing.
- Accepts a byte address over a valid/ready request port.
- Runs BURST back-to-back asynchronous SRAM read cycles with consecutive addresses, wrapping mod 128.
- Packs the bytes little-endian into one word and returns it over a valid/ready response port. Sits between the fetch/load logic and the SRAM array.

---
 rtl/sram_burst_reader_if.sv | 24 ++
 rtl/sram_burst_reader.sv | 89 ++++++++
 tb/tb_sram_burst_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_reader_if.sv
// Request/response handshake bundle for the SRAM burst reader.
// master = requester side, slave = controller side.
interface sram_burst_reader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int BURST  = 4
);
  logic                      req_valid;
  logic [ADDR_W-1:0]         req_addr;
  logic                      req_ready;
  logic                      rsp_valid;
  logic [BURST*DATA_W-1:0]   rsp_data;
  logic                      rsp_ready;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sram_burst_reader.sv
// Burst read controller for one async 128x8 SRAM macro.
// Reads BURST consecutive bytes and returns them packed little-endian.
module sram_burst_reader #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int BURST   = 4,
  parameter int ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_burst_reader_if.slave bus,
  output logic [ADDR_W-1:0] sram_a,
  inout  wire  [DATA_W-1:0] sram_dio,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(BURST - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]              state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic                    rsp_valid_q;
  logic [BURST*DATA_W-1:0] rsp_data_q;

  assign sram_we_n     = 1'b1;
  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // Sequence the burst: hold each address ACC_CYC cycles, sample on the last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_a      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      idx         <= '0;
      cnt         <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            sram_a    <= bus.req_addr;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            rsp_data_q[idx*DATA_W +: DATA_W] <= sram_dio;
            if (idx == IDX_LAST) begin
              sram_ce_n   <= 1'b1;
              sram_oe_n   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state       <= S_RESP;
            end else begin
              idx    <= idx + 1'b1;
              sram_a <= sram_a + 1'b1;
              cnt    <= '0;
            end
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Randomized bench for sram_burst_reader against an array-based
// SRAM model and a word-level expected-result function.
module tb_sram_burst_reader;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int BURST   = 4;
  localparam int ACC_CYC = 2;
  localparam int NCYC    = BURST * ACC_CYC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_burst_reader_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST)
  ) bus ();

  logic [ADDR_W-1:0] sram_a;
  wire  [DATA_W-1:0] sram_dio;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  logic [DATA_W-1:0] mem [0:127];

  assign sram_dio = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 8'bz;

  sram_burst_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BURST(BURST), .ACC_CYC(ACC_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sram_a    (sram_a),
    .sram_dio  (sram_dio),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int addr);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < BURST; i++)
      w[i*8 +: 8] = mem[(addr + i) % 128];
    return w;
  endfunction

  // Write enable must never assert.
  always @(negedge clk) check("we_n", 64'(sram_we_n), 64'd1);

  // One full request: accept, watch the access window, hold backpressure,
  // then handshake. With keep set, req_valid stays high carrying next_a.
  task automatic run_burst(input int a, input int hold,
                           input bit keep, input int next_a,
                           input bit chk_const,
                           input logic [31:0] const_word);
    logic [31:0] exp;
    exp = ref_word(a);
    check("ready_pre", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = 7'(a);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    if (!keep) bus.req_valid = 1'b0;
    else bus.req_addr = 7'(next_a);
    for (int k = 0; k < NCYC; k++) begin
      check("ce_oe_on", 64'({sram_ce_n, sram_oe_n}), 64'd0);
      check("addr", 64'(sram_a), 64'((a + k / ACC_CYC) % 128));
      check("valid_lo", 64'(bus.rsp_valid), 64'd0);
      check("ready_busy", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    check("valid_hi", 64'(bus.rsp_valid), 64'd1);
    check("ce_oe_off", 64'({sram_ce_n, sram_oe_n}), 64'd3);
    check("data", 64'(bus.rsp_data), 64'(exp));
    if (chk_const) check("data_const", 64'(bus.rsp_data), 64'(const_word));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_data", 64'(bus.rsp_data), 64'(exp));
      check("bp_ready", 64'(bus.req_ready), 64'd0);
      check("bp_ce_oe", 64'({sram_ce_n, sram_oe_n}), 64'd3);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("hs_valid", 64'(bus.rsp_valid), 64'd0);
    check("hs_ready", 64'(bus.req_ready), 64'd1);
    check("hs_ce_oe", 64'({sram_ce_n, sram_oe_n}), 64'd3);
    check("hs_data", 64'(bus.rsp_data), 64'(exp));
  endtask

  int addrs [0:23];
  int n_rand;
  bit keep;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

    // Reset for two edges, then release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ce", 64'(sram_ce_n), 64'd1);
    check("rst_oe", 64'(sram_oe_n), 64'd1);
    check("rst_a", 64'(sram_a), 64'd0);
    check("rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_data", 64'(bus.rsp_data), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);

    // Plain burst at top of array.
    mem[7'h7C] = 8'h11; mem[7'h7D] = 8'h22;
    mem[7'h7E] = 8'h33; mem[7'h7F] = 8'h00;
    run_burst(32'h7C, 0, 1'b0, 0, 1'b1, 32'h00332211);
    @(negedge clk);

    // Address wrap 7F -> 00.
    mem[7'h7E] = 8'hFF; mem[7'h7F] = 8'h00;
    mem[7'h00] = 8'hA5; mem[7'h01] = 8'h5A;
    run_burst(32'h7E, 0, 1'b0, 0, 1'b1, 32'h5AA500FF);

    // Backpressure with a queued request, accepted right after handshake.
    run_burst(32'h20, 5, 1'b1, 32'h10, 1'b0, 32'h0);
    run_burst(32'h10, 0, 1'b0, 0, 1'b0, 32'h0);

    // Reset while the third byte is being read.
    bus.req_valid = 1'b1;
    bus.req_addr  = 7'h30;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2 * ACC_CYC) @(negedge clk);
    check("mid_addr", 64'(sram_a), 64'h32);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_ce_oe", 64'({sram_ce_n, sram_oe_n}), 64'd3);
    check("mid_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_ready", 64'(bus.req_ready), 64'd1);
    rst_n = 1'b1;
    for (int k = 0; k < NCYC + 2; k++) begin
      @(negedge clk);
      check("post_valid", 64'(bus.rsp_valid), 64'd0);
      check("post_ce", 64'(sram_ce_n), 64'd1);
    end

    // Back-to-back 00 then 04.
    run_burst(32'h00, 0, 1'b1, 32'h04, 1'b0, 32'h0);
    run_burst(32'h04, 0, 1'b0, 0, 1'b0, 32'h0);
    @(negedge clk);

    // Random addresses, backpressure and chaining.
    n_rand = 24;
    for (int i = 0; i < n_rand; i++) begin
      addrs[i] = (i % 4 == 0) ? int'($urandom_range(124, 127))
                              : int'($urandom_range(0, 127));
    end
    for (int i = 0; i < n_rand; i++) begin
      keep = (i < n_rand - 1) && ($urandom_range(0, 1) == 1);
      run_burst(addrs[i], int'($urandom_range(0, 3)), keep,
                (i < n_rand - 1) ? addrs[i + 1] : 0, 1'b0, 32'h0);
      if (!keep && $urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
